rv64_imm_gen: RTL and testbench



---
 rtl/rv64_imm_gen.sv | 69 ++++++
 tb/tb_rv64_imm_gen.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/rv64_imm_gen.sv
// rv64_imm_gen: registered RV64I/M instruction-format classifier and immediate generator
module rv64_imm_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] inst,
  output logic        out_valid,
  output logic [2:0]  inst_type,
  output logic [63:0] imm
);
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_R32  = 7'b0111011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_IMM32= 7'b0011011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_SYS  = 7'b1110011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUIPC= 7'b0010111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3;
  localparam logic [2:0] T_U = 3'd4, T_J = 3'd5, T_NONE = 3'd7;
  logic [6:0]  opcode;
  logic        s;
  logic        is_r, is_i, is_s, is_b, is_u, is_j;
  logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        out_valid_d, out_valid_q;
  logic [2:0]  inst_type_d, inst_type_q;
  logic [63:0] imm_d, imm_q;
  // decode the opcode into a format and build every candidate immediate
  always_comb begin
    opcode = inst[6:0];
    s      = inst[31];
    is_r   = opcode == OP_R || opcode == OP_R32;
    is_i   = opcode == OP_IMM || opcode == OP_IMM32 || opcode == OP_LOAD ||
             opcode == OP_JALR || opcode == OP_SYS;
    is_s   = opcode == OP_ST;
    is_b   = opcode == OP_BR;
    is_u   = opcode == OP_LUI || opcode == OP_AUIPC;
    is_j   = opcode == OP_JAL;
    imm_i  = {{52{s}}, inst[31:20]};
    imm_s  = {{52{s}}, inst[31:25], inst[11:7]};
    imm_b  = {{51{s}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    imm_u  = {{32{s}}, inst[31:12], 12'b0};
    imm_j  = {{43{s}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    inst_type_d = is_r ? T_R : is_i ? T_I : is_s ? T_S : is_b ? T_B :
                  is_u ? T_U : is_j ? T_J : T_NONE;
    imm_d = is_i ? imm_i : is_s ? imm_s : is_b ? imm_b :
            is_u ? imm_u : is_j ? imm_j : 64'd0;
    out_valid_d = in_valid;
  end
  // output registers; reset wins over any instruction sampled at the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      inst_type_q <= T_NONE;
      imm_q       <= 64'd0;
    end else begin
      out_valid_q <= out_valid_d;
      inst_type_q <= inst_type_d;
      imm_q       <= imm_d;
    end
  end
  assign out_valid = out_valid_q;
  assign inst_type = inst_type_q;
  assign imm       = imm_q;
endmodule

// File: tb/tb_rv64_imm_gen.sv
// tb_rv64_imm_gen: scoreboard bench for the immediate generator
module tb_rv64_imm_gen;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] inst = 32'h0;
  logic        out_valid;
  logic [2:0]  inst_type;
  logic [63:0] imm;
  typedef struct {
    logic        v;
    logic [2:0]  t;
    logic [63:0] im;
    string       name;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int n_cmp = 0;
  int n_err = 0;
  rv64_imm_gen dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .inst(inst),
    .out_valid(out_valid), .inst_type(inst_type), .imm(imm)
  );
  always #5 clk = ~clk;
  task automatic drive(input logic r, input logic v, input logic [31:0] w,
                       input logic [2:0] t, input logic [63:0] im, input string nm);
    exp_t x;
    rst = r; in_valid = v; inst = w;
    x.v = r ? 1'b0 : v;
    x.t = r ? 3'd7 : t;
    x.im = r ? 64'd0 : im;
    x.name = nm;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask
  function automatic void model(input logic [31:0] w, output logic [2:0] t, output logic [63:0] im);
    logic [11:0] f12;
    logic [12:0] f13;
    logic [20:0] f21;
    t = 3'd7; im = 64'd0;
    case (w[6:0])
      7'h33, 7'h3B: t = 3'd0;
      7'h13, 7'h1B, 7'h03, 7'h67, 7'h73: begin
        t = 3'd1; im = 64'($signed({w, 32'b0}) >>> 52);
      end
      7'h23: begin
        t = 3'd2; f12 = {w[31:25], w[11:7]}; im = {{52{f12[11]}}, f12};
      end
      7'h63: begin
        t = 3'd3; f13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; im = {{51{f13[12]}}, f13};
      end
      7'h37, 7'h17: begin
        t = 3'd4; im = 64'($signed({w[31:12], 44'b0}) >>> 32);
      end
      7'h6F: begin
        t = 3'd5; f21 = {w[31], w[19:12], w[20], w[30:21], 1'b0}; im = {{43{f21[20]}}, f21};
      end
      default: ;
    endcase
  endfunction
  task automatic test_reset;
    drive(1, 1, 32'hFFF00093, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, "reset0");
    e = sb.pop_front(); n_cmp++;
    if (out_valid !== e.v || inst_type !== e.t || imm !== e.im) begin
      n_err++;
      $display("FAIL %s: got v=%b t=%0d imm=%h exp v=%b t=%0d imm=%h", e.name, out_valid, inst_type, imm, e.v, e.t, e.im);
    end
    drive(1, 0, 32'h0, 3'd7, 64'd0, "reset1");
    e = sb.pop_front(); n_cmp++;
    if (out_valid !== e.v || inst_type !== e.t || imm !== e.im) begin
      n_err++;
      $display("FAIL %s: got v=%b t=%0d imm=%h exp v=%b t=%0d imm=%h", e.name, out_valid, inst_type, imm, e.v, e.t, e.im);
    end
  endtask
  task automatic test_formats;
    logic [31:0] w[12] = '{32'hFFF00093, 32'h4030D093, 32'h0020B423, 32'hFE000EE3,
                           32'h800000B7, 32'h001000EF, 32'h00000073, 32'h00100073,
                           32'h30200073, 32'h30529073, 32'h022080B3, 32'h0000007F};
    logic [2:0]  t[12] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd7};
    logic [63:0] m[12] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h403, 64'h8, 64'hFFFF_FFFF_FFFF_FFFC,
                           64'hFFFF_FFFF_8000_0000, 64'h800, 64'h0, 64'h1,
                           64'h302, 64'h305, 64'h0, 64'h0};
    string n[12] = '{"addi_neg", "srai", "sd", "beq_neg", "lui_neg", "jal", "ecall",
                     "ebreak", "mret", "csrrw", "mul", "unknown"};
    for (int i = 0; i < 12; i++) begin
      drive(0, 1, w[i], t[i], m[i], n[i]);
      e = sb.pop_front(); n_cmp++;
      if (out_valid !== e.v || inst_type !== e.t || imm !== e.im) begin
        n_err++;
        $display("FAIL %s: got v=%b t=%0d imm=%h exp v=%b t=%0d imm=%h", e.name, out_valid, inst_type, imm, e.v, e.t, e.im);
      end
    end
  endtask
  task automatic test_back_to_back;
    logic [31:0] w[4] = '{32'h0020B423, 32'h800000B7, 32'hFE000EE3, 32'h001000EF};
    logic [2:0]  t;
    logic [63:0] m;
    for (int i = 0; i < 4; i++) begin
      model(w[i], t, m);
      drive(0, 1, w[i], t, m, $sformatf("b2b%0d", i));
      e = sb.pop_front(); n_cmp++;
      if (out_valid !== e.v || inst_type !== e.t || imm !== e.im) begin
        n_err++;
        $display("FAIL %s: got v=%b t=%0d imm=%h exp v=%b t=%0d imm=%h", e.name, out_valid, inst_type, imm, e.v, e.t, e.im);
      end
    end
  endtask
  task automatic test_reset_midstream;
    logic [31:0] w[6] = '{32'hFFF00093, 32'h0020B423, 32'h800000B7, 32'h001000EF, 32'hFE000EE3, 32'h022080B3};
    logic        r[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        v[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [2:0]  t;
    logic [63:0] m;
    for (int i = 0; i < 6; i++) begin
      model(w[i], t, m);
      drive(r[i], v[i], w[i], t, m, $sformatf("mid%0d", i));
      e = sb.pop_front(); n_cmp++;
      if (out_valid !== e.v || inst_type !== e.t || imm !== e.im) begin
        n_err++;
        $display("FAIL %s: got v=%b t=%0d imm=%h exp v=%b t=%0d imm=%h", e.name, out_valid, inst_type, imm, e.v, e.t, e.im);
      end
    end
  endtask
  task automatic test_random;
    logic [6:0]  ops[13] = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h67, 7'h73,
                             7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h0B};
    logic [31:0] w;
    logic [2:0]  t;
    logic [63:0] m;
    for (int i = 0; i < 60; i++) begin
      w = {$urandom()} ;
      w[6:0] = ops[$urandom_range(0, 12)];
      model(w, t, m);
      drive(0, 1'($urandom_range(0, 1)), w, t, m, $sformatf("rand%0d", i));
      e = sb.pop_front(); n_cmp++;
      if (out_valid !== e.v || inst_type !== e.t || imm !== e.im) begin
        n_err++;
        $display("FAIL %s: got v=%b t=%0d imm=%h exp v=%b t=%0d imm=%h inst=%h", e.name, out_valid, inst_type, imm, e.v, e.t, e.im, w);
      end
    end
  endtask
  initial begin
    test_reset;
    test_formats;
    test_back_to_back;
    test_reset_midstream;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
